// File: rtl/capt_sched.sv
`default_nettype none
// ============================================================================
//  Module   : capt_sched
//  Purpose  : Capture scheduler - queues packet descriptors and hands them one
//             at a time to a write controller, with timeout and wrap-halt.
//  Options  : CAPT_SCHED_STATS_EN enables the statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
module capt_sched #(
    parameter int DESC_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        desc_valid,
    input  logic [15:0] desc_len,
    output logic        desc_ready,
    input  logic        enable,
    input  logic        stop_on_wrap,
    input  logic        clear_err,
    output logic        wr_ctrl,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    input  logic        wr_ctrl_rdy,
    input  logic        capt_buf_wrap,
    input  logic [31:0] last_write_addr,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] pkt_count,
    output logic [31:0] byte_count,
    output logic [15:0] wrap_count,
    output logic [15:0] drop_count,
    output logic [31:0] last_addr
);

    localparam int c_AW    = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_HALT      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t              r_state, w_next;
    logic [15:0]         r_mem [DESC_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]       r_count;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_wrap;
    logic [15:0]         r_cur_len;
    logic [31:0]         r_pkt_begin, r_pkt_end;

    logic        w_full, w_empty, w_push, w_pop, w_issue, w_done;
    logic        w_in_xfer, w_cnt_hit, w_wrap;
    logic [15:0] w_head;

    assign w_full     = (r_count == (c_AW+1)'(DESC_DEPTH));
    assign w_empty    = (r_count == '0);
    assign desc_ready = reset && !w_full;
    assign w_push     = desc_valid && desc_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_in_xfer  = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK) ||
                        (r_state == S_WAIT_DONE);
    assign w_cnt_hit  = (r_cnt >= c_CNT_W'(TIMEOUT_CYCLES - 1));
    // The wrap seen on the completing cycle itself still counts
    assign w_wrap     = r_wrap || capt_buf_wrap;

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_issue = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head == 16'd0) begin
                        w_pop = 1'b1;
                    end else if (enable && wr_ctrl_rdy) begin
                        w_pop   = 1'b1;
                        w_issue = 1'b1;
                        w_next  = S_ISSUE;
                    end
                end
            end
            S_ISSUE:     w_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!wr_ctrl_rdy)   w_next = S_WAIT_DONE;
                else if (w_cnt_hit) w_next = S_ERR;
            end
            S_WAIT_DONE: begin
                if (wr_ctrl_rdy) begin
                    w_done = 1'b1;
                    w_next = (w_wrap && stop_on_wrap) ? S_HALT : S_IDLE;
                end else if (w_cnt_hit) begin
                    w_next = S_ERR;
                end
            end
            S_HALT:      if (!enable)   w_next = S_IDLE;
            S_ERR:       if (clear_err) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= desc_len;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cnt       <= '0;
            r_wrap      <= 1'b0;
            r_cur_len   <= '0;
            r_pkt_begin <= '0;
            r_pkt_end   <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_issue) begin
                r_pkt_begin <= '0;
                r_pkt_end   <= {16'd0, w_head};
                r_cur_len   <= w_head;
                r_wrap      <= 1'b0;
                r_cnt       <= '0;
            end else if (w_in_xfer) begin
                r_wrap <= w_wrap;
                if (r_state != S_ISSUE && !w_cnt_hit) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign wr_ctrl   = (r_state == S_ISSUE);
    assign busy      = w_in_xfer;
    assign halted    = (r_state == S_HALT);
    assign err       = (r_state == S_ERR);
    assign pkt_begin = r_pkt_begin;
    assign pkt_end   = r_pkt_end;

`ifdef CAPT_SCHED_STATS_EN
    logic [31:0] r_pkt_count, r_byte_count, r_last_addr;
    logic [15:0] r_wrap_count, r_drop_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
            r_last_addr  <= '0;
            r_wrap_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_done) begin
                r_pkt_count  <= r_pkt_count + 1'b1;
                r_byte_count <= r_byte_count + {16'd0, r_cur_len};
                r_last_addr  <= last_write_addr;
                if (w_wrap && r_wrap_count != 16'hFFFF)
                    r_wrap_count <= r_wrap_count + 1'b1;
            end
            if (desc_valid && !desc_ready && r_drop_count != 16'hFFFF)
                r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign pkt_count  = r_pkt_count;
    assign byte_count = r_byte_count;
    assign wrap_count = r_wrap_count;
    assign drop_count = r_drop_count;
    assign last_addr  = r_last_addr;
`else
    logic w_unused;
    assign w_unused   = ^{last_write_addr, r_cur_len};
    assign pkt_count  = '0;
    assign byte_count = '0;
    assign wrap_count = '0;
    assign drop_count = '0;
    assign last_addr  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_capt_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capt_sched
//  Purpose  : Scoreboard bench for capt_sched with a write-controller model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_capt_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, desc_valid, desc_ready, enable, stop_on_wrap, clear_err;
    logic        wr_ctrl, wr_ctrl_rdy, capt_buf_wrap, busy, halted, err;
    logic [15:0] desc_len, wrap_count, drop_count;
    logic [31:0] pkt_begin, pkt_end, last_write_addr, pkt_count, byte_count, last_addr;

    logic        t_reset, t_desc_valid, t_desc_ready, t_enable, t_clear_err;
    logic        t_wr_ctrl, t_busy, t_halted, t_err;
    logic [15:0] t_desc_len, t_wrap_count, t_drop_count;
    logic [31:0] t_pkt_begin, t_pkt_end, t_pkt_count, t_byte_count, t_last_addr;

    capt_sched #(.DESC_DEPTH(4), .TIMEOUT_CYCLES(256)) dut (
        .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_len(desc_len),
        .desc_ready(desc_ready), .enable(enable), .stop_on_wrap(stop_on_wrap),
        .clear_err(clear_err), .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin),
        .pkt_end(pkt_end), .wr_ctrl_rdy(wr_ctrl_rdy), .capt_buf_wrap(capt_buf_wrap),
        .last_write_addr(last_write_addr), .busy(busy), .halted(halted), .err(err),
        .pkt_count(pkt_count), .byte_count(byte_count), .wrap_count(wrap_count),
        .drop_count(drop_count), .last_addr(last_addr)
    );

    // Short-timeout instance whose write controller never acknowledges
    capt_sched #(.DESC_DEPTH(4), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .reset(t_reset), .desc_valid(t_desc_valid), .desc_len(t_desc_len),
        .desc_ready(t_desc_ready), .enable(t_enable), .stop_on_wrap(1'b0),
        .clear_err(t_clear_err), .wr_ctrl(t_wr_ctrl), .pkt_begin(t_pkt_begin),
        .pkt_end(t_pkt_end), .wr_ctrl_rdy(1'b1), .capt_buf_wrap(1'b0),
        .last_write_addr(32'h0), .busy(t_busy), .halted(t_halted), .err(t_err),
        .pkt_count(t_pkt_count), .byte_count(t_byte_count), .wrap_count(t_wrap_count),
        .drop_count(t_drop_count), .last_addr(t_last_addr)
    );

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] st(input logic [63:0] v);
`ifdef CAPT_SCHED_STATS_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    // Reference model state
    logic [15:0] exp_q[$];
    logic [15:0] cur_len;
    logic [31:0] m_pkts = 0, m_bytes = 0, m_last = 0;
    logic [15:0] m_wraps = 0, m_drops = 0;
    int          n_pulses = 0, t_n_pulses = 0;
    logic        prev_wr = 1'b0;
    event        wc_ev;
    int          wc_drop = 2, wc_busy = 20;
    bit          wc_wrap = 0, wc_abort = 0, wc_active = 0;

    always @(negedge clk) begin
        if (reset && wr_ctrl) begin
            n_pulses++;
            check("wr_ctrl_single_cycle", prev_wr, 0);
            check("pkt_begin", pkt_begin, 0);
            check("issue_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                cur_len = exp_q.pop_front();
                check("pkt_end", pkt_end, {48'd0, cur_len});
                ->wc_ev;
            end
        end
        prev_wr = reset && wr_ctrl;
        if (t_reset && t_wr_ctrl) t_n_pulses++;
    end

    // Write controller model: drop rdy, optional wrap pulse, then complete
    always begin
        logic [15:0] len;
        @(wc_ev);
        len = cur_len;
        wc_active = 1;
        repeat (wc_drop) @(posedge clk);
        #1 wr_ctrl_rdy = 0;
        if (wc_wrap) begin
            @(posedge clk); #1 capt_buf_wrap = 1;
            @(posedge clk); #1 capt_buf_wrap = 0;
        end
        repeat (wc_busy) @(posedge clk);
        #1;
        last_write_addr = $urandom;
        wr_ctrl_rdy = 1;
        if (wc_abort) wc_abort = 0;
        else begin
            m_pkts  = m_pkts + 1;
            m_bytes = m_bytes + {16'd0, len};
            m_last  = last_write_addr;
            if (wc_wrap && m_wraps != 16'hFFFF) m_wraps = m_wraps + 1;
        end
        wc_active = 0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] len, input bit exp_acc);
        desc_valid = 1; desc_len = len;
        @(negedge clk);
        check("desc_ready", desc_ready, exp_acc);
        if (exp_acc && len != 0) exp_q.push_back(len);
        tick(1);
        desc_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int  n = 0;
        bit  ok = 0;
        while (n < 600 && !ok) begin
            ok = (exp_q.size() == 0) && !wc_active && !busy;
            if (!ok) begin tick(1); n++; end
        end
        check({"idle_reached_", tag}, ok, 1);
        tick(2);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (n < 30 && !busy) begin tick(1); n++; end
        check({"busy_reached_", tag}, busy, 1);
    endtask

    task automatic check_stats(input string tag);
        check({"pkt_count_", tag},  pkt_count,  st(m_pkts));
        check({"byte_count_", tag}, byte_count, st(m_bytes));
        check({"wrap_count_", tag}, wrap_count, st(m_wraps));
        check({"drop_count_", tag}, drop_count, st(m_drops));
        check({"last_addr_", tag},  last_addr,  st(m_last));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int p, n;
        logic [15:0] len;
        reset = 0; desc_valid = 0; desc_len = 0; enable = 0; stop_on_wrap = 0;
        clear_err = 0; wr_ctrl_rdy = 1; capt_buf_wrap = 0; last_write_addr = 0;
        t_reset = 0; t_desc_valid = 0; t_desc_len = 0; t_enable = 0; t_clear_err = 0;
        tick(3);
        check("rst_flags", {wr_ctrl, busy, halted, err, desc_ready}, 0);
        check("rst_pkt_regs", {pkt_begin, pkt_end}, 0);
        check("rst_stats_a", {pkt_count, byte_count}, 0);
        check("rst_stats_b", {wrap_count, drop_count, last_addr}, 0);
        reset = 1; t_reset = 1;
        tick(2);
        check("ready_after_reset", desc_ready, 1);

        // Basic transfer of 0x3c
        enable = 1; p = n_pulses;
        push_one(16'h3c, 1);
        wait_idle("basic");
        check("basic_pulses", n_pulses - p, 1);
        check_stats("basic");

        // Queue fill while busy: 4 accepted, 5th dropped
        p = n_pulses;
        push_one(16'h11, 1);
        wait_busy("fill");
        for (int i = 0; i < 5; i++) begin
            desc_valid = 1; desc_len = 16'h20 + 16'(i);
            @(negedge clk);
            check("fill_ready", desc_ready, (i < 4));
            if (i < 4) exp_q.push_back(desc_len);
            tick(1);
        end
        desc_valid = 0;
        m_drops = m_drops + 1;
        wait_idle("fill");
        check("fill_pulses", n_pulses - p, 5);
        check_stats("fill");

        // Wrap with stop_on_wrap: halt until enable toggles
        stop_on_wrap = 1; wc_wrap = 1;
        push_one(16'hf2, 1);
        wait_busy("wrap");
        push_one(16'h21, 1);
        n = 0;
        while (n < 100 && !halted) begin tick(1); n++; end
        check("halted_reached", halted, 1);
        wc_wrap = 0; p = n_pulses;
        tick(10);
        check("halt_holds_queue", n_pulses - p, 0);
        check("halt_busy", busy, 0);
        check_stats("wrap");
        enable = 0;
        tick(3);
        check("halt_left", halted, 0);
        check("no_issue_disabled", n_pulses - p, 0);
        enable = 1;
        wait_idle("after_halt");
        check("after_halt_pulses", n_pulses - p, 1);
        stop_on_wrap = 0;
        check_stats("after_halt");

        // Zero-length head is discarded
        p = n_pulses;
        push_one(16'h0, 1);
        push_one(16'h10, 1);
        wait_idle("zero");
        check("zero_pulses", n_pulses - p, 1);
        check_stats("zero");

        // Randomised transfers, some with enable dropped mid-transfer
        for (int it = 0; it < 12; it++) begin
            len = ($urandom_range(0, 6) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
            wc_drop = $urandom_range(1, 3);
            wc_busy = $urandom_range(2, 15);
            wc_wrap = $urandom_range(0, 1);
            p = n_pulses;
            push_one(len, 1);
            if (len != 0 && it[0]) begin
                wait_busy("rand");
                enable = 0;
            end
            wait_idle("rand");
            enable = 1;
            check("rand_pulses", n_pulses - p, (len != 0));
        end
        wc_wrap = 0;
        check_stats("rand");

        // Reset in WAIT_DONE flushes queue and statistics
        wc_drop = 2; wc_busy = 30;
        push_one(16'h55, 1);
        wait_busy("rst");
        push_one(16'h66, 1);
        n = 0;
        while (n < 20 && wr_ctrl_rdy) begin tick(1); n++; end
        tick(2);
        check("rst_in_wait_done", {busy, wr_ctrl_rdy}, 2'b10);
        reset = 0; wc_abort = 1; exp_q.delete();
        m_pkts = 0; m_bytes = 0; m_last = 0; m_wraps = 0; m_drops = 0;
        tick(1);
        check("mid_rst_flags", {wr_ctrl, busy, halted, err, desc_ready}, 0);
        check("mid_rst_stats", {pkt_count, byte_count}, 0);
        check("mid_rst_pkt_end", pkt_end, 0);
        reset = 1; p = n_pulses;
        n = 0;
        while (n < 60 && wc_active) begin tick(1); n++; end
        tick(20);
        check("no_pulse_after_rst", n_pulses - p, 0);
        check("ready_after_mid_rst", desc_ready, 1);
        check_stats("post_rst");

        // Timeout on the short-timeout instance
        t_enable = 1; p = t_n_pulses;
        t_desc_valid = 1; t_desc_len = 16'h40;
        tick(1);
        t_desc_valid = 0;
        n = 0;
        while (n < 20 && !t_wr_ctrl) begin tick(1); n++; end
        check("to_issue", t_wr_ctrl, 1);
        n = 0;
        while (n < 100 && !t_err) begin tick(1); n++; end
        check("to_cycles", n, 17);
        check("to_err_flags", {t_err, t_busy}, 2'b10);
        t_desc_valid = 1; t_desc_len = 16'h22;
        tick(1);
        t_desc_valid = 0;
        tick(5);
        check("to_err_holds", {t_err, 32'(t_n_pulses - p)}, {1'b1, 32'd1});
        t_clear_err = 1;
        tick(1);
        t_clear_err = 0;
        n = 0;
        while (n < 20 && !t_wr_ctrl) begin tick(1); n++; end
        check("to_reissue", {t_wr_ctrl, t_err, t_pkt_end}, {1'b1, 1'b0, 32'h22});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capt_sched.md
CAPT_SCHED -- requirements
Module: capt_sched

Interface
REQ-001 SHALL have parameter DESC_DEPTH, default 4, descriptor queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles per transfer before an error is flagged.
REQ-003 SHALL have a single clock and a synchronous, active-low reset: port clk and port reset, with reset=0 meaning in reset.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 desc_valid  in  1  packet descriptor offered.
REQ-007 desc_len  in  16  packet length in bytes.
REQ-008 desc_ready  out  1  queue can accept a descriptor.
REQ-009 enable  in  1  capture enable.
REQ-010 stop_on_wrap  in  1  halt after a transfer that wrapped the capture buffer.
REQ-011 clear_err  in  1  single-cycle pulse that leaves ERR.
REQ-012 wr_ctrl  out  1  start pulse to the write controller.
REQ-013 pkt_begin  out  32  packet start offset.
REQ-014 pkt_end  out  32  packet end offset.
REQ-015 wr_ctrl_rdy  in  1  write controller idle.
REQ-016 capt_buf_wrap  in  1  write controller wrapped the capture buffer.
REQ-017 last_write_addr  in  32  write controller's final address.
REQ-018 busy, halted, err  out  1 each  state flags.
REQ-019 pkt_count, byte_count  out  32 each; wrap_count, drop_count  out  16 each; last_addr  out  32  statistics.

Function
REQ-020 Queue: FIFO of DESC_DEPTH x 16 bits; desc_ready = not full; push when desc_valid && desc_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 drop_count SHALL increment, saturating at 0xFFFF, on every cycle with desc_valid && !desc_ready.
REQ-022 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, HALT, ERR.
REQ-023 IDLE -> ISSUE on the cycle after queue non-empty && enable && wr_ctrl_rdy; the head is popped on that transition, and pkt_begin=0, pkt_end=zero-extended desc_len are registered.
REQ-024 Zero-length head: SHALL be popped in IDLE without issuing; no counter changes; FSM stays in IDLE.
REQ-025 ISSUE: wr_ctrl=1 for exactly one cycle, then -> WAIT_ACK.
REQ-026 WAIT_ACK -> WAIT_DONE when wr_ctrl_rdy=0.
REQ-027 WAIT_DONE -> IDLE when wr_ctrl_rdy=1.
REQ-028 capt_buf_wrap SHALL be latched sticky across ISSUE, WAIT_ACK and WAIT_DONE.
REQ-029 At WAIT_DONE exit: pkt_count+=1; byte_count+=desc_len (modulo 2^32); last_addr<=last_write_addr; if sticky wrap then wrap_count+=1 (saturating).
REQ-030 At WAIT_DONE exit with sticky wrap && stop_on_wrap: -> HALT instead of IDLE.
REQ-031 HALT -> IDLE when enable=0; the queue is retained.
REQ-032 Cycle counter: cleared on entering ISSUE; counts in WAIT_ACK and WAIT_DONE; reaching TIMEOUT_CYCLES -> ERR.
REQ-033 ERR -> IDLE only on clear_err; the queue is retained.
REQ-034 pkt_begin/pkt_end SHALL stay stable from ISSUE until the next IDLE->ISSUE transition.
REQ-035 Flags: busy=1 in ISSUE, WAIT_ACK and WAIT_DONE; halted=1 in HALT; err=1 in ERR.
REQ-036 enable deasserted mid-transfer SHALL NOT abort the transfer; it only blocks new issues.

Reset
REQ-037 reset=0 at a rising edge: FSM=IDLE, queue empty, wr_ctrl=0, pkt_begin=0, pkt_end=0, all flags 0, all counters and last_addr 0.
REQ-038 Reset SHALL take effect mid-transfer with no further wr_ctrl pulse; desc_ready SHALL be 0 while in reset.

Configuration
REQ-039 Macro CAPT_SCHED_STATS_EN: when defined, pkt_count, byte_count, wrap_count, drop_count and last_addr SHALL be implemented per REQ-021 and REQ-029.
REQ-040 When CAPT_SCHED_STATS_EN is undefined, those outputs SHALL be constant 0, while wrap latching and HALT behaviour remain unchanged.

Verification
REQ-041 Push len 0x3c, enable=1, write controller model drops rdy 2 cycles after wr_ctrl and raises it 20 cycles later -> one wr_ctrl pulse, pkt_end=0x3c, pkt_count=1, byte_count=0x3c.
REQ-042 Push 5 descriptors back-to-back with DESC_DEPTH=4 while busy -> desc_ready=0 on the 5th, drop_count=1, exactly 4 transfers issued in order.
REQ-043 Len 0xf2 with capt_buf_wrap pulsed during transfer and stop_on_wrap=1 -> wrap_count=1, halted=1, queued descriptor not issued until enable is toggled 0 then 1.
REQ-044 Model never drops rdy, TIMEOUT_CYCLES=16 -> err=1 after 16 cycles; clear_err -> IDLE, next descriptor issued.
REQ-045 Zero-length descriptor followed by len 0x10 -> only one wr_ctrl pulse, pkt_count=1.
REQ-046 Reset asserted in WAIT_DONE -> all outputs 0 on the next cycle, queue empty, no wr_ctrl pulse after release.
